// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the pc_seq program-flow sequencer.
package pc_seq_pkg;

  typedef enum logic {RUN, FLUSH} state_t;

  typedef enum logic [2:0] {NONE, IRQ, RTI, RET, CAL, JMP, BRZ} action_t;

  // Stack pointer must hold 0..depth inclusive.
  function automatic int unsigned sp_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_seq_ret_stack.sv
// Return-address LIFO: pointer resets, storage does not; top reads 0 when empty.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned NBITS = 8,
  parameter int unsigned SDEPT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [NBITS-1:0] din,
  output logic [NBITS-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = sp_width(SDEPT);

  logic [NBITS-1:0] mem [SDEPT];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_dec;

  assign full    = (ptr == PW'(SDEPT));
  assign empty   = (ptr == '0);
  assign ptr_dec = ptr - PW'(1);
  assign top     = empty ? '0 : mem[ptr_dec[PW-2:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push && !full) begin
      mem[ptr[PW-2:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-flow sequencer: decodes flow ops, drives counter load, owns return stack.
// Interrupt support is enabled by defining PC_SEQ_IRQ_EN.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int unsigned NBITS = 8,
  parameter int unsigned SDEPT = 8,
  parameter int unsigned FLSHN = 2,
  parameter int unsigned IRQAD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] pc_addr,
  input  logic             op_jmp,
  input  logic             op_brz,
  input  logic             zf,
  input  logic             op_cal,
  input  logic             op_ret,
  input  logic             op_rti,
  input  logic [NBITS-1:0] tgt,
  input  logic             irq,
  output logic             irq_ack,
  output logic             in_isr,
  output logic             pc_load,
  output logic [NBITS-1:0] pc_data,
  output logic             flush,
  output logic             err_ovf,
  output logic             err_unf
);

  state_t           state_q, state_d;
  action_t          act;
  action_t          rti_act;
  logic [2:0]       cnt_q;
  logic             flush_q;
  logic             ovf_q, unf_q;
  logic             irq_take;
  logic             push, pop;
  logic [NBITS-1:0] stk_top;
  logic             stk_full, stk_empty;

`ifdef PC_SEQ_IRQ_EN
  logic isr_q, ack_q;

  assign irq_take = irq & ~isr_q;
  assign rti_act  = RTI;
  assign in_isr   = isr_q;
  assign irq_ack  = ack_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      isr_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= (act == IRQ);
      if (act == IRQ) begin
        isr_q <= 1'b1;
      end else if (act == RTI) begin
        isr_q <= 1'b0;
      end
    end
  end
`else
  logic unused_irq;

  assign unused_irq = irq;
  assign irq_take   = 1'b0;
  assign rti_act    = RET;
  assign in_isr     = 1'b0;
  assign irq_ack    = 1'b0;
`endif

  ret_stack #(
    .NBITS(NBITS),
    .SDEPT(SDEPT)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (pc_addr),
    .top  (stk_top),
    .full (stk_full),
    .empty(stk_empty)
  );

  always_comb begin
    act = NONE;
    if (rst && state_q == RUN) begin
      if (irq_take)            act = IRQ;
      else if (op_rti)         act = rti_act;
      else if (op_ret)         act = RET;
      else if (op_cal)         act = CAL;
      else if (op_jmp)         act = JMP;
      else if (op_brz && zf)   act = BRZ;
    end
  end

  // An empty pop still redirects: stk_top reads 0 in that case.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    pc_load = 1'b0;
    pc_data = '0;
    case (act)
      IRQ: begin
        push    = 1'b1;
        pc_load = 1'b1;
        pc_data = NBITS'(IRQAD);
      end
      RTI, RET: begin
        pop     = 1'b1;
        pc_load = 1'b1;
        pc_data = stk_top;
      end
      CAL: begin
        push    = 1'b1;
        pc_load = 1'b1;
        pc_data = tgt;
      end
      JMP, BRZ: begin
        pc_load = 1'b1;
        pc_data = tgt;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (pc_load) state_d = FLUSH;
      FLUSH:   if (cnt_q == 3'(FLSHN - 1)) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= (state_d == FLUSH);
      cnt_q   <= (state_q == FLUSH) ? cnt_q + 3'd1 : '0;
      ovf_q   <= ovf_q | (push & stk_full);
      unf_q   <= unf_q | (pop & stk_empty);
    end
  end

  assign flush   = flush_q;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Program-flow sequencer for the soft-core program counter.
- Decodes per-cycle flow requests: jump, conditional branch, call, return, interrupt entry and interrupt return.
- Drives the counter's load/data pair and owns a hardware return-address stack.
- Emits a flush window after every redirect so that fetch/decode discard instructions already in flight.

Parameters:
- NBITS, 8, instruction address width (matches the program counter).
- SDEPT, 8, return-stack depth in entries; must be a power of two, at least 2.
- FLSHN, 2, number of flush cycles asserted after every redirect; range 1..7.
- IRQAD, 1, interrupt vector address.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- pc_addr  input  NBITS  current counter output (next sequential address).
- op_jmp  input  1  unconditional jump to tgt.
- op_brz  input  1  branch to tgt if zf=1.
- zf  input  1  accumulator-zero flag.
- op_cal  input  1  call tgt; push pc_addr.
- op_ret  input  1  return; pop top of stack.
- op_rti  input  1  return from interrupt; pop and leave ISR.
- tgt  input  NBITS  branch/jump/call target.
- irq  input  1  level interrupt request.
- irq_ack  output  1  one-cycle pulse when an interrupt is taken.
- in_isr  output  1  executing the interrupt service routine.
- pc_load  output  1  to counter load.
- pc_data  output  NBITS  to counter data.
- flush  output  1  discard in-flight instructions.
- err_ovf  output  1  sticky: push attempted with the stack full.
- err_unf  output  1  sticky: pop attempted with the stack empty.

Behaviour:
- Reset (rst=0 at a rising edge):
  - State RUN; stack pointer 0; flush counter 0.
  - in_isr, irq_ack, flush, err_ovf, err_unf all 0.
  - pc_load=0, pc_data=0.
  - Reset mid-flush or mid-ISR aborts that activity; stack contents are not preserved.
- pc_load and pc_data are combinational from ops, state and stack top, so the counter captures them on the same edge. All other outputs are registered.
- States:
  - RUN: ops are decoded.
  - FLUSH: flush=1, all op_* and irq are ignored, pc_load=0. Stays FLUSH for FLSHN cycles, then returns to RUN.
- Priority in RUN, highest first; exactly one action per cycle:
  1. irq with in_isr=0: push pc_addr, load IRQAD, in_isr<=1, irq_ack pulse.
  2. op_rti: pop, load popped address, in_isr<=0.
  3. op_ret: pop, load popped address.
  4. op_cal: push pc_addr, load tgt.
  5. op_jmp: load tgt.
  6. op_brz with zf=1: load tgt.
- op_brz with zf=0 produces no redirect.
- Any load moves the state RUN->FLUSH on the next edge. While an interrupt is taken, the simultaneous op is dropped; the pushed pc_addr re-executes it after rti.
- Stack:
  - LIFO, top-of-stack read combinationally.
  - Push when full (SDEPT entries): no write, pointer unchanged, target still loaded, err_ovf<=1.
  - Pop when empty: pc_data=0, pc_load=1, err_unf<=1, pointer unchanged.
  - err_ovf and err_unf clear only on reset.
- irq while in_isr=1 is held pending; no nesting.
- All addresses are NBITS wide and are not incremented here (the counter adds 1).

Optional Feature:
- PC_SEQ_IRQ_EN defined: interrupt logic as described above.
- Not defined:
  - irq is ignored.
  - irq_ack and in_isr are tied to 0.
  - op_rti behaves exactly like op_ret.
  - ISR state flop is removed.

Decomposition:
- Package pc_seq_pkg:
  - State enum {RUN, FLUSH}.
  - Action enum {NONE, IRQ, RTI, RET, CAL, JMP, BRZ}.
  - Width function for the stack pointer, clog2(SDEPT)+1.
- One sub-module: ret_stack (parameterised LIFO with push/pop/full/empty/top).

Test Plan:
- Reset, then op_jmp tgt=0x40 → pc_load=1, pc_data=0x40 that cycle; flush=1 for 2 cycles; ops during flush ignored.
- op_cal tgt=0x20 at pc_addr=0x11, later op_ret → pc_data=0x20, then pc_data=0x11; stack empty afterwards; no error flags.
- 9 consecutive calls with SDEPT=8 → err_ovf=1 after the 9th; the 9th target is still loaded; 8 returns pop the correct addresses in reverse order.
- op_ret on empty stack → pc_load=1, pc_data=0, err_unf=1 and it stays set.
- irq with op_jmp in the same cycle at pc_addr=0x33 → pc_data=0x01, irq_ack pulse, in_isr=1; second irq ignored; op_rti → pc_data=0x33, in_isr=0.
- op_brz with zf=0 → no load, no flush; with zf=1, tgt=0x7F → load 0x7F.
